// File: rtl/icache_pkg.sv
// Shared configuration for the direct-mapped instruction cache:
// geometry, allocator request offset and FSM state encodings.
package icache_pkg;

  localparam int ICacheIndexWidth = 8;
  localparam int ICacheAddrWidth  = 32;
  localparam int ICacheDataWidth  = 32;
  localparam int ICacheTagWidth   = ICacheAddrWidth - ICacheIndexWidth - 2;

  // Allocator offset 3 means a 4-byte read.
  localparam logic [1:0] AllocInstrOffset = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    REQ    = 3'd2,
    WAIT   = 3'd3,
    FILL   = 3'd4
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and allocator-side signals of the instruction cache.
// The cache connects through the slave modport, its environment through master.
interface icache_if;
  import icache_pkg::*;

  logic                       clear_branch_in;
  logic                       fetch_en_in;
  logic [ICacheAddrWidth-1:0] fetch_pc_in;
  logic                       ic_ready_out;
  logic                       ic_valid_out;
  logic [ICacheDataWidth-1:0] ic_instr_out;
  logic [ICacheAddrWidth-1:0] ic_pc_out;
  logic                       alloc_en_out;
  logic [ICacheAddrWidth-1:0] alloc_a_out;
  logic [1:0]                 alloc_offset_out;
  logic                       alloc_gr_in;
  logic                       alloc_en_in;
  logic [ICacheDataWidth-1:0] alloc_d_in;

  modport master (
    output clear_branch_in, fetch_en_in, fetch_pc_in,
    output alloc_gr_in, alloc_en_in, alloc_d_in,
    input  ic_ready_out, ic_valid_out, ic_instr_out, ic_pc_out,
    input  alloc_en_out, alloc_a_out, alloc_offset_out
  );

  modport slave (
    input  clear_branch_in, fetch_en_in, fetch_pc_in,
    input  alloc_gr_in, alloc_en_in, alloc_d_in,
    output ic_ready_out, ic_valid_out, ic_instr_out, ic_pc_out,
    output alloc_en_out, alloc_a_out, alloc_offset_out
  );

endinterface

// File: rtl/icache_array.sv
// Tag/data storage with synchronous read and write, plus a valid-bit
// register file that is flash-cleared by reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_W = ICacheIndexWidth,
  parameter int TAG_W   = ICacheTagWidth,
  parameter int DATA_W  = ICacheDataWidth
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rd_en,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int Lines = 1 << INDEX_W;

  logic [TAG_W-1:0]  tag_ram  [Lines];
  logic [DATA_W-1:0] data_ram [Lines];
  logic [Lines-1:0]  valid_q;

  // RAM contents need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_ram[wr_idx]  <= wr_tag;
      data_ram[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tag_ram[rd_idx];
      rd_data <= data_ram[rd_idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) valid_q[wr_idx] <= 1'b1;
      if (rd_en) rd_valid <= valid_q[rd_idx];
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits return two edges
// after the request; misses fetch the word through the allocator and fill the line.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICacheIndexWidth,
  parameter int ADDR_WIDTH  = ICacheAddrWidth
) (
  input logic     clk_in,
  input logic     rst_in,
  input logic     rdy_in,
  icache_if.slave bus
);

  localparam int TagWidth = ADDR_WIDTH - INDEX_WIDTH - 2;

  icache_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
  logic                      valid_q, valid_d;
  logic [ICacheDataWidth-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]     pc_out_q, pc_out_d;
  logic                      alloc_en_q, alloc_en_d;
  logic [ADDR_WIDTH-1:0]     alloc_a_q, alloc_a_d;
  logic                      rd_en, wr_en;
  logic                      rd_valid;
  logic [TagWidth-1:0]       rd_tag;
  logic [ICacheDataWidth-1:0] rd_data;
  logic                      hit;

  icache_array #(
    .INDEX_W (INDEX_WIDTH),
    .TAG_W   (TagWidth),
    .DATA_W  (ICacheDataWidth)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_en    (rd_en && rdy_in),
    .rd_idx   (bus.fetch_pc_in[INDEX_WIDTH+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en && rdy_in),
    .wr_idx   (pc_q[INDEX_WIDTH+1:2]),
    .wr_tag   (pc_q[ADDR_WIDTH-1:INDEX_WIDTH+2]),
    .wr_data  (bus.alloc_d_in)
  );

  assign hit = rd_valid && (rd_tag == pc_q[ADDR_WIDTH-1:INDEX_WIDTH+2]);

  // Branch flush outranks everything, so it is checked before the state decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = 1'b0;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    alloc_en_d = alloc_en_q;
    alloc_a_d  = alloc_a_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    if (bus.clear_branch_in) begin
      state_d    = IDLE;
      alloc_en_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.fetch_en_in) begin
            pc_d    = bus.fetch_pc_in;
            rd_en   = 1'b1;
            state_d = LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            valid_d  = 1'b1;
            instr_d  = rd_data;
            pc_out_d = pc_q;
            state_d  = IDLE;
          end else begin
            alloc_en_d = 1'b1;
            alloc_a_d  = {pc_q[ADDR_WIDTH-1:2], 2'b00};
            state_d    = REQ;
          end
        end
        REQ: begin
          if (bus.alloc_gr_in) begin
            alloc_en_d = 1'b0;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (bus.alloc_en_in) begin
            wr_en   = 1'b1;
            instr_d = bus.alloc_d_in;
            state_d = FILL;
          end
        end
        FILL: begin
          valid_d  = 1'b1;
          pc_out_d = pc_q;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_out_q   <= '0;
      alloc_en_q <= 1'b0;
      alloc_a_q  <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      alloc_en_q <= alloc_en_d;
      alloc_a_q  <= alloc_a_d;
    end
  end

  assign bus.ic_ready_out     = (state_q == IDLE);
  assign bus.ic_valid_out     = valid_q;
  assign bus.ic_instr_out     = instr_q;
  assign bus.ic_pc_out        = pc_out_q;
  assign bus.alloc_en_out     = alloc_en_q;
  assign bus.alloc_a_out      = alloc_a_q;
  assign bus.alloc_offset_out = AllocInstrOffset;

endmodule

// File: tb/tb_icache.sv
// Directed and randomized fetch sequences against a line-level reference
// model of a direct-mapped cache and a simple allocator responder.
module tb_icache;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  icache_if bus ();

  icache dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int tests  = 0;
  int failed = 0;

  // Reference model: 256 lines, index = word address mod 256, tag = pc / 1024.
  bit          m_valid [256];
  logic [31:0] m_tag   [256];
  logic [31:0] m_data  [256];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic invalidateModel();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  // One complete fetch; the model decides hit or miss, the allocator answers misses.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] fill,
                               input int gnt_dly, input int dat_dly);
    int          idx;
    logic [31:0] tag;
    bit          hit;
    idx = int'((pc >> 2) & 32'hFF);
    tag = pc >> 10;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    checkOutput("ready_idle", 32'(bus.ic_ready_out), 1);
    bus.fetch_en_in = 1'b1;
    bus.fetch_pc_in = pc;
    tick();
    bus.fetch_en_in = 1'b0;
    checkOutput("ready_busy", 32'(bus.ic_ready_out), 0);
    tick();
    if (hit) begin
      checkOutput("hit_valid", 32'(bus.ic_valid_out), 1);
      checkOutput("hit_instr", bus.ic_instr_out, m_data[idx]);
      checkOutput("hit_pc", bus.ic_pc_out, pc);
      checkOutput("hit_no_alloc", 32'(bus.alloc_en_out), 0);
    end else begin
      checkOutput("miss_alloc_en", 32'(bus.alloc_en_out), 1);
      checkOutput("miss_alloc_a", bus.alloc_a_out, pc & 32'hFFFF_FFFC);
      checkOutput("miss_offset", 32'(bus.alloc_offset_out), 3);
      checkOutput("miss_no_valid", 32'(bus.ic_valid_out), 0);
      for (int i = 0; i < gnt_dly; i++) begin
        tick();
        checkOutput("req_hold", 32'(bus.alloc_en_out), 1);
      end
      bus.alloc_gr_in = 1'b1;
      tick();
      bus.alloc_gr_in = 1'b0;
      checkOutput("gnt_drop", 32'(bus.alloc_en_out), 0);
      for (int i = 0; i < dat_dly; i++) begin
        tick();
        checkOutput("wait_addr", bus.alloc_a_out, pc & 32'hFFFF_FFFC);
      end
      bus.alloc_en_in = 1'b1;
      bus.alloc_d_in  = fill;
      tick();
      bus.alloc_en_in = 1'b0;
      bus.alloc_d_in  = $urandom;
      checkOutput("fill_early", 32'(bus.ic_valid_out), 0);
      tick();
      checkOutput("fill_valid", 32'(bus.ic_valid_out), 1);
      checkOutput("fill_instr", bus.ic_instr_out, fill);
      checkOutput("fill_pc", bus.ic_pc_out, pc);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_data[idx]  = fill;
    end
    tick();
    checkOutput("pulse_end", 32'(bus.ic_valid_out), 0);
  endtask

  int          pulses;
  logic [31:0] rpc;

  initial begin
    rst_in              = 1'b1;
    rdy_in              = 1'b1;
    bus.clear_branch_in = 1'b0;
    bus.fetch_en_in     = 1'b0;
    bus.fetch_pc_in     = '0;
    bus.alloc_gr_in     = 1'b0;
    bus.alloc_en_in     = 1'b0;
    bus.alloc_d_in      = '0;
    invalidateModel();
    repeat (3) tick();
    rst_in = 1'b0;
    tick();

    checkOutput("rst_ready", 32'(bus.ic_ready_out), 1);
    checkOutput("rst_valid", 32'(bus.ic_valid_out), 0);
    checkOutput("rst_alloc_en", 32'(bus.alloc_en_out), 0);
    checkOutput("rst_alloc_a", bus.alloc_a_out, 0);
    checkOutput("rst_instr", bus.ic_instr_out, 0);
    checkOutput("rst_pc", bus.ic_pc_out, 0);

    // Cold miss, re-fetch hit, then a conflict pair on index 0
    applyStimulus(32'h0000_1000, 32'h0010_0093, 0, 0);
    applyStimulus(32'h0000_1000, 32'h0, 0, 0);
    applyStimulus(32'h0000_1400, 32'hDEAD_BEEF, 1, 2);
    applyStimulus(32'h0000_1000, 32'h0010_0093, 2, 1);

    // Stalled and flushed requests are not accepted
    rdy_in          = 1'b0;
    bus.fetch_en_in = 1'b1;
    bus.fetch_pc_in = 32'h0000_5000;
    tick();
    bus.fetch_en_in = 1'b0;
    rdy_in          = 1'b1;
    tick();
    checkOutput("stall_no_accept", 32'(bus.ic_ready_out), 1);
    bus.clear_branch_in = 1'b1;
    bus.fetch_en_in     = 1'b1;
    tick();
    bus.clear_branch_in = 1'b0;
    bus.fetch_en_in     = 1'b0;
    checkOutput("flush_drops_fetch", 32'(bus.ic_ready_out), 1);

    // Flush in WAIT coincident with the data pulse
    bus.fetch_en_in = 1'b1;
    bus.fetch_pc_in = 32'h0000_2000;
    tick();
    bus.fetch_en_in = 1'b0;
    tick();
    checkOutput("flush_miss", 32'(bus.alloc_en_out), 1);
    bus.alloc_gr_in = 1'b1;
    tick();
    bus.alloc_gr_in = 1'b0;
    tick();
    bus.clear_branch_in = 1'b1;
    bus.alloc_en_in     = 1'b1;
    bus.alloc_d_in      = 32'h1111_2222;
    tick();
    bus.clear_branch_in = 1'b0;
    bus.alloc_en_in     = 1'b0;
    checkOutput("flush_ready", 32'(bus.ic_ready_out), 1);
    checkOutput("flush_no_valid", 32'(bus.ic_valid_out), 0);
    tick();
    checkOutput("flush_no_valid2", 32'(bus.ic_valid_out), 0);
    applyStimulus(32'h0000_1000, 32'h0, 0, 0);
    applyStimulus(32'h0000_2000, 32'h1111_2222, 1, 1);

    // Grant withheld for 10 cycles while rdy_in toggles
    bus.fetch_en_in = 1'b1;
    bus.fetch_pc_in = 32'h0000_3004;
    tick();
    bus.fetch_en_in = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      rdy_in = 1'($urandom_range(0, 1));
      tick();
      checkOutput("stall_req_hold", 32'(bus.alloc_en_out), 1);
    end
    rdy_in          = 1'b1;
    bus.alloc_gr_in = 1'b1;
    tick();
    bus.alloc_gr_in = 1'b0;
    checkOutput("stall_gnt_drop", 32'(bus.alloc_en_out), 0);
    rdy_in = 1'b0;
    tick();
    checkOutput("stall_no_regrant", 32'(bus.alloc_en_out), 0);
    rdy_in          = 1'b1;
    bus.alloc_en_in = 1'b1;
    bus.alloc_d_in  = 32'hCAFE_F00D;
    tick();
    bus.alloc_en_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.ic_valid_out) begin
        pulses++;
        checkOutput("stall_fill_instr", bus.ic_instr_out, 32'hCAFE_F00D);
      end
    end
    checkOutput("stall_single_fill", pulses, 1);
    m_valid[1] = 1'b1;
    m_tag[1]   = 32'h0000_3004 >> 10;
    m_data[1]  = 32'hCAFE_F00D;
    applyStimulus(32'h0000_3004, 32'h0, 0, 0);

    // Reset while a request is outstanding
    bus.fetch_en_in = 1'b1;
    bus.fetch_pc_in = 32'h0000_4008;
    tick();
    bus.fetch_en_in = 1'b0;
    tick();
    checkOutput("rstreq_alloc_en", 32'(bus.alloc_en_out), 1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    checkOutput("rstreq_drop", 32'(bus.alloc_en_out), 0);
    checkOutput("rstreq_ready", 32'(bus.ic_ready_out), 1);
    invalidateModel();
    applyStimulus(32'h0000_1000, 32'h0010_0093, 0, 1);
    applyStimulus(32'h0000_3004, 32'h0BAD_CAFE, 1, 0);

    // Randomized traffic over a few conflicting tags and indices
    for (int n = 0; n < 40; n++) begin
      rpc = 32'h0001_0000 + (32'($urandom_range(0, 3)) << 10) + (32'($urandom_range(0, 7)) << 2);
      applyStimulus(rpc, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
